// File: rtl/pixel_stream_sequencer.sv
// rtl/pixel_stream_sequencer.sv - frame sequencer: streams an NxN image to the kernel bank, then reads results back
//
// Purpose:
//   Write phase: fetches pixels from frame memory and broadcasts them in raster
//   order (px_we=1). After GAP_BEATS idle beats, a read-out phase sweeps the same
//   addresses (px_we=0), captures each kernel result and writes it to a result buffer.
//   Every bus value is held for one beat (2 clk cycles).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle frame start pulse (honoured only in IDLE)
//   fm_addr / fm_data     frame-memory read address / data
//   px_addr/px_data/px_we broadcast bus to the kernel units
//   res_pixel/res_harris  kernel results
//   out_we/out_addr/out_data/out_harris  result-buffer write port
//   busy, done            status
module pixel_stream_sequencer #(
  parameter int N           = 8,
  parameter int BITSIZE     = 6,
  parameter int PIXEL_WIDTH = 8,
  parameter int GAP_BEATS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [BITSIZE:0]       fm_addr,
  input  logic [PIXEL_WIDTH-1:0] fm_data,
  output logic [BITSIZE:0]       px_addr,
  output logic [PIXEL_WIDTH-1:0] px_data,
  output logic                   px_we,
  input  logic [PIXEL_WIDTH-1:0] res_pixel,
  input  logic                   res_harris,
  output logic                   out_we,
  output logic [BITSIZE:0]       out_addr,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_harris,
  output logic                   busy,
  output logic                   done
);

  localparam int AW   = BITSIZE + 1;
  localparam int NPIX = N * N;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] GAP_LAST  = AW'(GAP_BEATS - 1);

  if (NPIX > (2 ** AW)) begin : g_size_check
    $error("pixel_stream_sequencer: N*N does not fit in BITSIZE+1 address bits");
  end
  if (GAP_BEATS < 1) begin : g_gap_check
    $error("pixel_stream_sequencer: GAP_BEATS must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    STREAM   = 3'd2,
    GAP      = 3'd3,
    READOUT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t          state, state_next;
  logic            phase;     // 0 = first cycle of a beat, 1 = second
  logic [AW-1:0]   cnt;       // pixel index in STREAM/READOUT, beat index in GAP
  logic            last_px;

  assign last_px = (cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = PREFETCH;
      PREFETCH: state_next = STREAM;
      STREAM:   if (phase && last_px) state_next = GAP;
      GAP:      if (phase && (cnt == GAP_LAST)) state_next = READOUT;
      // Leave only after the buffer write of the final pixel has been issued.
      READOUT:  if (out_we && (out_addr == LAST_ADDR)) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      cnt        <= '0;
      px_data    <= '0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_harris <= 1'b0;
    end else begin
      phase <= (state inside {STREAM, GAP, READOUT}) ? ~phase : 1'b0;

      case (state)
        STREAM:  if (phase) cnt <= last_px ? '0 : cnt + 1'b1;
        GAP:     if (phase) cnt <= (cnt == GAP_LAST) ? '0 : cnt + 1'b1;
        // Saturate on the last pixel so the trailing write cycle keeps a legal px_addr.
        READOUT: if (phase && !last_px) cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase

      // Load the pixel for the upcoming beat; after the last beat px_data holds.
      if ((state == PREFETCH) || ((state == STREAM) && phase && !last_px)) begin
        px_data <= fm_data;
      end

      out_we <= (state == READOUT) && phase;
      if ((state == READOUT) && phase) begin
        out_addr   <= cnt;
        out_data   <= res_pixel;
        out_harris <= res_harris;
      end
    end
  end

  // Prefetch address k+1 in phase 1 of beat k; never step past the last pixel.
  always_comb begin
    fm_addr = '0;
    if (state == STREAM) begin
      fm_addr = (phase && !last_px) ? cnt + 1'b1 : cnt;
    end
  end

  assign px_addr = ((state == STREAM) || (state == READOUT)) ? cnt : '0;
  assign px_we   = (state == STREAM);
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// tb/tb_pixel_stream_sequencer.sv - self-checking bench for pixel_stream_sequencer
module tb_pixel_stream_sequencer;

  localparam int NP  = 64;
  localparam int G   = 2;
  localparam int TOT = 4 * NP + 2 * G + 3;
  localparam int G0  = 2 + 2 * NP;
  localparam int R0  = G0 + 2 * G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start11;

  logic [6:0] fm_addr, px_addr, out_addr;
  logic [7:0] fm_data, px_data, res_pixel, out_data;
  logic       px_we, res_harris, out_we, out_harris, busy, done;

  logic [6:0] b_fm_addr, b_px_addr, b_out_addr;
  logic [7:0] b_fm_data, b_px_data, b_res_pixel, b_out_data;
  logic       b_px_we, b_res_harris, b_out_we, b_out_harris, b_busy, b_done;

  always #5 clk = ~clk;

  assign fm_data      = {1'b0, fm_addr} ^ 8'h5A;
  assign res_pixel    = {1'b0, px_addr} + 8'd3;
  assign res_harris   = px_addr[0];
  assign b_fm_data    = {1'b0, b_fm_addr} ^ 8'h5A;
  assign b_res_pixel  = {1'b0, b_px_addr} + 8'd3;
  assign b_res_harris = b_px_addr[0];

  pixel_stream_sequencer #(.N(8), .BITSIZE(6), .PIXEL_WIDTH(8), .GAP_BEATS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fm_addr(fm_addr), .fm_data(fm_data),
    .px_addr(px_addr), .px_data(px_data), .px_we(px_we),
    .res_pixel(res_pixel), .res_harris(res_harris),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .out_harris(out_harris),
    .busy(busy), .done(done)
  );

  pixel_stream_sequencer #(.N(11), .BITSIZE(6), .PIXEL_WIDTH(8), .GAP_BEATS(2)) dut11 (
    .clk(clk), .rst_n(rst_n), .start(start11),
    .fm_addr(b_fm_addr), .fm_data(b_fm_data),
    .px_addr(b_px_addr), .px_data(b_px_data), .px_we(b_px_we),
    .res_pixel(b_res_pixel), .res_harris(b_res_harris),
    .out_we(b_out_we), .out_addr(b_out_addr), .out_data(b_out_data), .out_harris(b_out_harris),
    .busy(b_busy), .done(b_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pat(input int a);
    return (a ^ 'h5A) & 'hFF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Frame model: m_t is the cycle offset from the cycle in which start was accepted.
  logic m_active = 1'b0;
  int   m_t = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (m_active) begin
      if (m_t == TOT) m_active <= 1'b0;
      else            m_t <= m_t + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_t      <= 1;
    end
  end

  int done_q[$];
  int we_cnt   = 0;
  int first_we = -1;
  int b_max    = 0;
  int b_done_c = -1;

  always @(negedge clk) begin : compare
    int s, k, r, oa, e_fm, e_pxa, e_pxd;
    bit e_busy, e_done, e_pxwe, e_owe, chk_pxd;
    e_busy = 0; e_done = 0; e_pxwe = 0; e_owe = 0; chk_pxd = 0;
    e_fm = 0; e_pxa = 0; e_pxd = 0; oa = 0;
    if (m_active) begin
      e_busy = (m_t < TOT);
      e_done = (m_t == TOT);
      if (m_t >= 2 && m_t < G0) begin
        s = m_t - 2; k = s / 2;
        e_pxwe = 1; e_pxa = k; e_pxd = pat(k); chk_pxd = 1;
        e_fm = (s % 2 == 1) ? ((k + 1 < NP) ? k + 1 : k) : k;
      end else if (m_t >= G0 && m_t < R0) begin
        e_pxd = pat(NP - 1); chk_pxd = 1;
      end else if (m_t >= R0 && m_t < TOT) begin
        r = m_t - R0;
        e_pxa = (r / 2 < NP) ? r / 2 : NP - 1;
        if (r >= 2 && r % 2 == 0) begin
          e_owe = 1; oa = r / 2 - 1;
        end
      end
    end
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("px_we", int'(px_we), int'(e_pxwe));
    chk("px_addr", int'(px_addr), e_pxa);
    chk("fm_addr", int'(fm_addr), e_fm);
    chk("out_we", int'(out_we), int'(e_owe));
    if (chk_pxd) chk("px_data", int'(px_data), e_pxd);
    if (e_owe) begin
      chk("out_addr", int'(out_addr), oa);
      chk("out_data", int'(out_data), (oa + 3) & 'hFF);
      chk("out_harris", int'(out_harris), oa % 2);
    end
    if (!rst_n) begin
      chk("rst_px_data", int'(px_data), 0);
      chk("rst_out_addr", int'(out_addr), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_harris", int'(out_harris), 0);
      chk("rst_busy11", int'(b_busy), 0);
    end
    if (done) done_q.push_back(cyc);
    if (out_we) we_cnt++;
    if (px_we && first_we < 0) first_we = cyc;
    if (int'(b_px_addr) > b_max) b_max = int'(b_px_addr);
    if (int'(b_fm_addr) > b_max) b_max = int'(b_fm_addr);
    if (b_done) b_done_c = cyc;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base, s0, s2;

  initial begin
    rst_n = 1'b0; start = 1'b1; start11 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_px_we", int'(px_we), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fm_addr", int'(fm_addr), 0);
    start = 1'b0; start11 = 1'b0; rst_n = 1'b1;
    base = cyc;
    wait_cyc(base + 5);
    chk("idle_busy", int'(busy), 0);
    chk("idle_px_addr", int'(px_addr), 0);

    wait_cyc(base + 10); start = 1'b1; start11 = 1'b1;
    wait_cyc(base + 11); start = 1'b0; start11 = 1'b0;
    wait_cyc(base + 12);
    chk("beat0_px_we", int'(px_we), 1);
    chk("beat0_px_data", int'(px_data), 'h5A);
    wait_cyc(base + 22);
    chk("beat5_px_addr", int'(px_addr), 5);
    chk("beat5_px_data", int'(px_data), 'h5F);
    wait_cyc(base + 50); start = 1'b1;
    wait_cyc(base + 51); start = 1'b0;
    wait_cyc(base + 146);
    chk("first_out_we", int'(out_we), 1);
    chk("first_out_data", int'(out_data), 3);
    chk("first_out_addr", int'(out_addr), 0);
    wait_cyc(base + 148);
    chk("second_out_data", int'(out_data), 4);
    chk("second_out_harris", int'(out_harris), 1);
    wait_cyc(base + 273);
    chk("done_at_273", int'(done), 1);
    start = 1'b1;
    wait_cyc(base + 274);
    chk("idle_after_done", int'(busy), 0);
    wait_cyc(base + 275);
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);

    wait_cyc(base + 560);
    chk("done_count", done_q.size(), 2);
    chk("done1_cycle", (done_q.size() > 0) ? done_q[0] : -1, base + 273);
    chk("done2_cycle", (done_q.size() > 1) ? done_q[1] : -1, base + 537);
    chk("out_we_pulses", we_cnt, 128);
    chk("first_px_we_cycle", first_we, base + 12);
    chk("n11_done_cycle", b_done_c, base + 10 + 4 * 121 + 7);
    chk("n11_max_addr", b_max, 120);

    s0 = cyc + 2;
    wait_cyc(s0); start = 1'b1;
    wait_cyc(s0 + 1); start = 1'b0;
    wait_cyc(s0 + 42);
    chk("beat20_px_addr", int'(px_addr), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_px_we", int'(px_we), 0);
    chk("midrst_out_we", int'(out_we), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_px_addr", int'(px_addr), 0);
    wait_cyc(s0 + 44);
    rst_n = 1'b1;
    s2 = s0 + 46;
    wait_cyc(s2); start = 1'b1;
    wait_cyc(s2 + 1); start = 1'b0;
    wait_cyc(s2 + 2);
    chk("restart_px_addr", int'(px_addr), 0);
    chk("restart_px_we", int'(px_we), 1);
    chk("restart_px_data", int'(px_data), 'h5A);
    wait_cyc(s2 + 263);
    chk("restart_done", int'(done), 1);
    wait_cyc(s2 + 268);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
